// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory-ready timeouts.
// Strobes decode from the registered state; only ir_load, dmem_we and rf_we also see inputs.
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             dec_reg_write,
  input  logic             dec_mem_write,
  input  logic             dec_mem_to_reg,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             pc_inc,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_last;
  logic              is_halt_op;
  logic              is_mem_op;

  // The cycle whose missed ready would bring the count to MEM_TIMEOUT; ready still wins here.
  assign wait_last  = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
  assign is_halt_op = (opcode == 4'b1110) || (opcode == 4'b1111);
  assign is_mem_op  = dec_mem_write || dec_mem_to_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      halted   <= 1'b0;
      fault    <= 1'b0;
      retired  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          if (run) state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ready) begin
            state <= S_DECODE;
          end else if (wait_last) begin
            state  <= S_HALT;
            halted <= 1'b1;
            fault  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          if (is_halt_op) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          wait_cnt <= '0;
          state    <= is_mem_op ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (dmem_ready) begin
            state <= S_WB;
          end else if (wait_last) begin
            state  <= S_HALT;
            halted <= 1'b1;
            fault  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WB: begin
          retired  <= retired + CNT_W'(1);
          wait_cnt <= '0;
          state    <= run ? S_FETCH : S_IDLE;
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state  <= S_HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req = (state == S_FETCH);
  assign ir_load  = (state == S_FETCH) && imem_ready;
  assign dmem_req = (state == S_MEM);
  assign dmem_we  = (state == S_MEM) && dec_mem_write;
  assign rf_we    = (state == S_WB) && dec_reg_write;
  assign pc_inc   = (state == S_WB);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: instruction-level model of expected per-cycle outputs.
module tb_cpu_sequencer;

  localparam int CW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [3:0]    opcode;
  logic          dec_reg_write, dec_mem_write, dec_mem_to_reg;
  logic          imem_ready, dmem_ready;
  logic          imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_inc;
  logic [2:0]    state;
  logic          halted, fault;
  logic [CW-1:0] retired;

  int errors = 0;
  int checks = 0;
  int exp_ret;
  bit exp_idle;

  cpu_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .dec_reg_write(dec_reg_write), .dec_mem_write(dec_mem_write),
    .dec_mem_to_reg(dec_mem_to_reg), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_load(ir_load),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .pc_inc(pc_inc),
    .state(state), .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // flags = {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_inc, halted, fault}
  task automatic chk_out(input string tag, input logic [2:0] st, input logic [7:0] flags);
    chk(tag, {21'd0, state, imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_inc, halted, fault},
        {21'd0, st, flags});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    tick();
    rst = 1'b0;
    mid();
    chk_out("reset_out", 3'd0, 8'h00);
    chk("reset_retired", retired, 0);
    exp_ret  = 0;
    exp_idle = 1'b1;
    tick();
  endtask

  // One instruction from the spec's view: df missed fetch readies, dm missed data readies.
  // Called just after an edge; returns just after the edge that ends the instruction.
  task automatic do_instr(input int df, input logic [3:0] opc, input logic rw,
                          input logic mw, input logic m2r, input int dm, input logic run_after);
    if (exp_idle) begin
      run = 1'b0;
      for (int k = 0; k < $urandom_range(0, 2); k++) begin
        mid();
        chk_out("idle_hold", 3'd0, 8'h00);
        tick();
      end
      run = 1'b1;
      mid();
      chk_out("idle_go", 3'd0, 8'h00);
      chk("idle_retired", retired, exp_ret);
      tick();
      exp_idle = 1'b0;
    end
    for (int i = 0; i < TO; i++) begin
      imem_ready = (i == df);
      mid();
      chk_out("fetch", 3'd1, {1'b1, (i == df), 6'b0});
      if (i == 0) chk("retired", retired, exp_ret);
      tick();
      imem_ready = 1'b0;
      if (i == df) break;
    end
    if (df >= TO) return;
    opcode = opc;
    dec_reg_write = rw;
    dec_mem_write = mw;
    dec_mem_to_reg = m2r;
    run = run_after;
    mid();
    chk_out("decode", 3'd2, 8'h00);
    tick();
    if (opc >= 4'd14) return;
    mid();
    chk_out("exec", 3'd3, 8'h00);
    tick();
    if (mw || m2r) begin
      for (int j = 0; j < TO; j++) begin
        dmem_ready = (j == dm);
        mid();
        chk_out("mem", 3'd4, {2'b0, 1'b1, mw, 4'b0});
        tick();
        dmem_ready = 1'b0;
        if (j == dm) break;
      end
      if (dm >= TO) return;
    end
    mid();
    chk_out("wb", 3'd5, {4'b0, rw, 1'b1, 2'b0});
    tick();
    exp_ret  = (exp_ret + 1) % (1 << CW);
    exp_idle = !run_after;
  endtask

  task automatic halt_hold(input int n, input logic exp_fault);
    for (int k = 0; k < n; k++) begin
      run = k[0];
      mid();
      chk_out("halt_state", 3'd6, {6'b0, 1'b1, exp_fault});
      chk("halt_retired", retired, exp_ret);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    opcode = 4'd0;
    dec_reg_write = 1'b0;
    dec_mem_write = 1'b0;
    dec_mem_to_reg = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    exp_ret = 0;
    exp_idle = 1'b1;
    tick();
    do_reset();

    // Back-to-back ALU instructions: 4 cycles each.
    for (int n = 0; n < 3; n++) do_instr(0, 4'b0011, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    // Store with data ready three cycles late, then a single-cycle load.
    do_instr(0, 4'b0101, 1'b0, 1'b1, 1'b0, 3, 1'b1);
    do_instr(0, 4'b0110, 1'b1, 1'b0, 1'b1, 0, 1'b1);

    // Random mix; run often drops mid-instruction. Enough instructions to wrap retired.
    for (int n = 0; n < 24; n++) begin
      do_instr($urandom_range(0, 3), 4'($urandom_range(0, 13)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 4),
               ($urandom_range(0, 3) != 0));
    end

    // Ready arriving on the last permitted wait cycle wins over the timeout.
    do_instr(TO - 1, 4'b0001, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    do_instr(0, 4'b0010, 1'b1, 1'b0, 1'b1, TO - 1, 1'b1);

    // Halt opcode: sticky, no fault, retired frozen, run ignored.
    do_instr(0, 4'b1111, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    halt_hold(4, 1'b0);
    do_reset();
    do_instr(0, 4'b1110, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    halt_hold(2, 1'b0);
    do_reset();

    // Reset while a store is waiting in MEM.
    do_instr(0, 4'b0100, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    do_instr(1, 4'b0100, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run = 1'b1;
    mid();
    chk_out("pre_mem_idle", 3'd0, 8'h00);
    tick();
    imem_ready = 1'b1;
    mid();
    chk_out("pre_mem_fetch", 3'd1, 8'hC0);
    tick();
    imem_ready = 1'b0;
    opcode = 4'b0000;
    dec_reg_write = 1'b0;
    dec_mem_write = 1'b1;
    dec_mem_to_reg = 1'b0;
    mid();
    tick();
    mid();
    tick();
    mid();
    chk_out("pre_rst_mem", 3'd4, 8'h30);
    chk("pre_rst_retired", retired, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run = 1'b0;
    mid();
    chk_out("rst_in_mem", 3'd0, 8'h00);
    chk("rst_in_mem_retired", retired, 0);
    exp_ret = 0;
    exp_idle = 1'b1;
    tick();

    // Instruction memory never answers: fault after the full wait budget.
    do_instr(TO + 50, 4'b0001, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    halt_hold(4, 1'b1);
    do_reset();

    // Data memory never answers.
    do_instr(0, 4'b0111, 1'b0, 1'b1, 1'b0, TO + 50, 1'b1);
    halt_hold(2, 1'b1);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
